// File: rtl/calc_pkg.sv
// Shared types and command codes for the keypad-to-calculator command sequencer.
package calc_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {
        ERRO    = 2'b00,
        PRONTA  = 2'b01,
        OCUPADA = 2'b10
    } calc_status_e;

    localparam logic [KEY_W-1:0] SOMA     = 4'b1010;
    localparam logic [KEY_W-1:0] SUBT     = 4'b1011;
    localparam logic [KEY_W-1:0] MULT     = 4'b1100;
    localparam logic [KEY_W-1:0] IDLE_CMD = 4'b1101;
    localparam logic [KEY_W-1:0] IGUAL    = 4'b1110;
    localparam logic [KEY_W-1:0] BACKS    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_FLUSH  = 2'b11
    } seq_state_e;

    // Hold codes never carry a command, so they are never queued.
    function automatic logic is_hold_code(input logic [KEY_W-1:0] code,
                                          input logic [KEY_W-1:0] hold);
        return (code == IDLE_CMD) || (code == hold);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Key command FIFO: power-of-two depth, flop storage, combinational head.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_d;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Queues keypad commands and feeds them to the calculator one at a time,
// pacing on calculator status and flushing the queue after an error.
module calc_cmd_sequencer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [3:0]  IDLE_CMD = 4'b1101
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [3:0]             key_code,
    output logic                   key_ready,
    input  logic [1:0]             calc_status,
    output logic [3:0]             calc_cmd,
    output logic                   cmd_issued,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    import calc_pkg::*;

    seq_state_e       state_q;
    seq_state_e       state_d;
    calc_status_e     status;
    logic [KEY_W-1:0] cmd_d;
    logic             issued_d;
    logic             pop;
    logic [KEY_W-1:0] head;
    logic             full;
    logic             empty;
    logic             key_live;
    logic             push;
    logic             drop;

    assign status    = calc_status_e'(calc_status);
    assign key_live  = key_valid && !is_hold_code(key_code, IDLE_CMD);
    assign push      = key_live && (!full || pop);
    assign drop      = key_live && full && !pop;
    assign key_ready = !full;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (key_code),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Next state and next registered outputs; SETTLE falls through the IDLE
    // decision so back-to-back commands keep a two-cycle cadence.
    always_comb begin
        state_d  = state_q;
        cmd_d    = IDLE_CMD;
        issued_d = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE, ST_SETTLE: begin
                state_d = ST_IDLE;
                if (status == ERRO) begin
                    state_d = ST_FLUSH;
                end else if (status == PRONTA && !empty) begin
                    state_d  = ST_ISSUE;
                    cmd_d    = head;
                    issued_d = 1'b1;
                    pop      = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
            end
            ST_FLUSH: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head == BACKS) begin
                        state_d  = ST_ISSUE;
                        cmd_d    = head;
                        issued_d = 1'b1;
                    end
                end else if (status != ERRO) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            calc_cmd   <= IDLE_CMD;
            cmd_issued <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            calc_cmd   <= cmd_d;
            cmd_issued <= issued_d;
            overflow   <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed vector bench for calc_cmd_sequencer (DEPTH=8, hold code 1101).
module tb_calc_cmd_sequencer;

    localparam logic [1:0] S_ERRO = 2'b00;
    localparam logic [1:0] S_PRON = 2'b01;
    localparam logic [1:0] S_OCUP = 2'b10;
    localparam logic [3:0] HC     = 4'hD;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [1:0] calc_status;
    logic [3:0] calc_cmd;
    logic       cmd_issued;
    logic [3:0] fifo_count;
    logic       overflow;

    int checks;
    int failures;

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic [1:0] st;
        logic [3:0] cmd;
        logic       iss;
        logic [3:0] cnt;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t vecs[25];

    calc_cmd_sequencer #(
        .DEPTH    (8),
        .IDLE_CMD (4'b1101)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .calc_cmd    (calc_cmd),
        .cmd_issued  (cmd_issued),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t v(input logic kv, input logic [3:0] code, input logic [1:0] st,
                               input logic [3:0] cmd, input logic iss, input logic [3:0] cnt,
                               input logic rdy, input logic ovf);
        vec_t r;
        r.kv = kv; r.code = code; r.st = st;
        r.cmd = cmd; r.iss = iss; r.cnt = cnt; r.rdy = rdy; r.ovf = ovf;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] cmd, input logic iss,
                           input logic [3:0] cnt, input logic rdy, input logic ovf);
        checks++;
        if ({calc_cmd, cmd_issued, fifo_count, key_ready, overflow} !== {cmd, iss, cnt, rdy, ovf}) begin
            failures++;
            $display("FAIL %s: got cmd=%h iss=%0d cnt=%0d rdy=%0d ovf=%0d, expected cmd=%h iss=%0d cnt=%0d rdy=%0d ovf=%0d",
                     name, calc_cmd, cmd_issued, fifo_count, key_ready, overflow,
                     cmd, iss, cnt, rdy, ovf);
        end
    endtask

    task automatic do_reset(input logic [1:0] st);
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; calc_status = st;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_key(input logic [3:0] code);
        key_valid = 1'b1; key_code = code;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;

        // Back-to-back issue, hold-code discard, then overflow and full push+pop.
        vecs[0]  = v(1, 4'h3, S_PRON, HC,   0, 4'd1, 1, 0);
        vecs[1]  = v(1, 4'hA, S_PRON, 4'h3, 1, 4'd1, 1, 0);
        vecs[2]  = v(1, 4'h4, S_PRON, HC,   0, 4'd2, 1, 0);
        vecs[3]  = v(1, 4'hE, S_PRON, 4'hA, 1, 4'd2, 1, 0);
        vecs[4]  = v(0, 4'h0, S_PRON, HC,   0, 4'd2, 1, 0);
        vecs[5]  = v(0, 4'h0, S_PRON, 4'h4, 1, 4'd1, 1, 0);
        vecs[6]  = v(0, 4'h0, S_PRON, HC,   0, 4'd1, 1, 0);
        vecs[7]  = v(0, 4'h0, S_PRON, 4'hE, 1, 4'd0, 1, 0);
        vecs[8]  = v(0, 4'h0, S_PRON, HC,   0, 4'd0, 1, 0);
        vecs[9]  = v(1, HC,   S_PRON, HC,   0, 4'd0, 1, 0);
        vecs[10] = v(0, 4'h0, S_PRON, HC,   0, 4'd0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            vecs[10+i] = v(1, 4'(i), S_OCUP, HC, 0, 4'(i), (i < 8), 0);
        end
        vecs[19] = v(1, HC,   S_OCUP, HC,   0, 4'd8, 0, 0);
        vecs[20] = v(1, 4'h9, S_OCUP, HC,   0, 4'd8, 0, 1);
        vecs[21] = v(1, 4'h5, S_PRON, 4'h1, 1, 4'd8, 0, 1);
        vecs[22] = v(0, 4'h0, S_OCUP, HC,   0, 4'd8, 0, 1);
        vecs[23] = v(0, 4'h0, S_OCUP, HC,   0, 4'd8, 0, 1);
        vecs[24] = v(0, 4'h0, S_PRON, 4'h2, 1, 4'd7, 1, 1);

        // Reset with a key present: the key must not be queued.
        reset = 1'b1; key_valid = 1'b1; key_code = 4'h3; calc_status = S_PRON;
        tick();
        tick();
        chk_all("reset_state", HC, 0, 4'd0, 1, 0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            key_valid   = vecs[i].kv;
            key_code    = vecs[i].code;
            calc_status = vecs[i].st;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].iss, vecs[i].cnt,
                    vecs[i].rdy, vecs[i].ovf);
        end
        key_valid = 1'b0;

        // Busy calculator holds the queue; first issue one cycle after it is ready.
        do_reset(S_OCUP);
        chk_all("reset_clears_overflow", HC, 0, 4'd0, 1, 0);
        push_key(4'h6);
        push_key(4'h7);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all($sformatf("busy_hold%0d", i), HC, 0, 4'd2, 1, 0);
        end
        calc_status = S_PRON;
        tick(); chk_all("resume_first", 4'h6, 1, 4'd1, 1, 0);
        tick(); chk_all("resume_settle", HC, 0, 4'd1, 1, 0);
        tick(); chk_all("resume_second", 4'h7, 1, 4'd0, 1, 0);

        // Error flush: discard up to backspace, issue it, resume after ready.
        do_reset(S_OCUP);
        push_key(4'h5);
        push_key(4'hC);
        push_key(4'hF);
        push_key(4'h7);
        calc_status = S_ERRO;
        tick(); chk_all("flush_enter", HC, 0, 4'd4, 1, 0);
        tick(); chk_all("flush_drop5", HC, 0, 4'd3, 1, 0);
        tick(); chk_all("flush_dropC", HC, 0, 4'd2, 1, 0);
        tick(); chk_all("flush_backsp", 4'hF, 1, 4'd1, 1, 0);
        calc_status = S_PRON;
        tick(); chk_all("flush_settle", HC, 0, 4'd1, 1, 0);
        tick(); chk_all("flush_after7", 4'h7, 1, 4'd0, 1, 0);

        // Empty FLUSH holds while in error, discards new keys, exits on recovery.
        calc_status = S_ERRO;
        tick();
        tick(); chk_all("flush_empty_hold", HC, 0, 4'd0, 1, 0);
        push_key(4'h2);
        chk_all("flush_push_in_err", HC, 0, 4'd1, 1, 0);
        tick(); chk_all("flush_discard2", HC, 0, 4'd0, 1, 0);
        calc_status = S_PRON;
        tick(); chk_all("flush_exit", HC, 0, 4'd0, 1, 0);
        push_key(4'h3);
        chk_all("post_flush_push", HC, 0, 4'd1, 1, 0);
        tick(); chk_all("post_flush_issue", 4'h3, 1, 4'd0, 1, 0);

        // Reset in the ISSUE cycle aborts and empties the queue.
        do_reset(S_OCUP);
        push_key(4'h1);
        push_key(4'h2);
        push_key(4'h3);
        push_key(4'h4);
        calc_status = S_PRON;
        tick(); chk_all("pre_reset_issue", 4'h1, 1, 4'd3, 1, 0);
        reset = 1'b1; key_valid = 1'b1; key_code = 4'h8;
        tick(); chk_all("reset_mid_issue", HC, 0, 4'd0, 1, 0);
        reset = 1'b0; key_valid = 1'b0;
        tick(); chk_all("after_abort", HC, 0, 4'd0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sequencer.md
CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, default 8, command FIFO depth (power of two, minimum 2).
REQ-002 Parameter: IDLE_CMD, default 4'b1101, hold code driven to the calculator when no command is issued.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_valid  input  1  key_code is valid this cycle.
REQ-006 key_code  input  4  keypad command: digit 0-9, 1010 add, 1011 sub, 1100 mul, 1110 equals, 1111 backspace.
REQ-007 key_ready  output  1  FIFO can accept a key; high when count<DEPTH.
REQ-008 calc_status  input  2  calculator state: 00 ERRO, 01 PRONTA, 10 OCUPADA.
REQ-009 calc_cmd  output  4  command presented to the calculator.
REQ-010 cmd_issued  output  1  one-cycle pulse while calc_cmd carries a real command.
REQ-011 fifo_count  output  $clog2(DEPTH)+1  number of queued keys.
REQ-012 overflow  output  1  sticky flag: a key was dropped while full.

Function
REQ-013 Key push: key_valid=1 and count<DEPTH stores key_code at the tail on that edge.
REQ-014 Key codes 4'b1101 and equal to IDLE_CMD shall be discarded without push and without setting overflow.
REQ-015 key_valid=1 with count==DEPTH shall drop the key and set overflow; overflow clears only on reset.
REQ-016 Simultaneous push and pop when full shall accept the push; count is unchanged.
REQ-017 FSM states: IDLE, ISSUE, SETTLE, FLUSH.
REQ-018 IDLE: calc_cmd=IDLE_CMD; on calc_status==PRONTA and count>0, go to ISSUE; on calc_status==ERRO, go to FLUSH; otherwise stay in IDLE.
REQ-019 ISSUE: calc_cmd=head, cmd_issued=1, pop head; next state is SETTLE; lasts exactly one cycle.
REQ-020 SETTLE: calc_cmd=IDLE_CMD for one cycle so the calculator status reflects the command; next state is IDLE.
REQ-021 OCUPADA in IDLE: hold IDLE_CMD indefinitely; no pop.
REQ-022 FLUSH: pop and discard one non-1111 head per cycle; a 1111 head is issued as in ISSUE, then the FSM goes to SETTLE; an empty FIFO holds FLUSH until status leaves ERRO, then goes to IDLE.
REQ-023 Latency: a key pushed at edge N into an empty FIFO with status PRONTA and FSM in IDLE shall appear on calc_cmd in cycle N+1.
REQ-024 Throughput: at most one command every two cycles.
REQ-025 Pointers shall wrap modulo DEPTH; count shall never exceed DEPTH or underflow.
REQ-026 calc_cmd and cmd_issued shall be registered outputs.

Reset
REQ-027 While reset=1 the block shall return to IDLE, empty the FIFO, and set calc_cmd=IDLE_CMD, cmd_issued=0, fifo_count=0, overflow=0, key_ready=1.
REQ-028 Reset mid-ISSUE/FLUSH shall abort without issuing; a key_valid in the reset cycle shall be ignored.

Structure
REQ-029 Package calc_pkg shall hold the calculator status enum (ERRO, PRONTA, OCUPADA), the command constants (SOMA, SUBT, MULT, IGUAL, BACKS, IDLE_CMD) and the sequencer state enum.
REQ-030 The FIFO shall be a sub-module cmd_fifo (push/pop/full/empty/count, synchronous reset); the FSM stays in calc_cmd_sequencer.

Verification
REQ-031 PRONTA, push 3,1010,4,1110 on consecutive cycles -> calc_cmd sequence 3,IDLE_CMD,1010,IDLE_CMD,4,IDLE_CMD,1110 with four cmd_issued pulses.
REQ-032 Status OCUPADA for 20 cycles with 2 keys queued -> calc_cmd=IDLE_CMD and fifo_count=2 throughout; first issue one cycle after status returns to PRONTA.
REQ-033 Push 9 keys with status OCUPADA (DEPTH=8) -> ninth dropped, overflow=1, key_ready=0, fifo_count=8.
REQ-034 Status ERRO with queue 5,1100,1111,7 -> 5 and 1100 discarded, 1111 issued; 7 is issued after status returns to PRONTA.
REQ-035 Assert reset during ISSUE with 3 queued -> next cycle fifo_count=0, calc_cmd=IDLE_CMD, cmd_issued=0, overflow=0.
